tile_timing_gen: RTL and testbench
==================================

// Module: tile_timing_gen
// PURPOSE
//  Parametrised clock-phase, H/V raster, interrupt and reset-delay generator for tile-layer chips.
//  Generalises the fixed 24 MHz timing front end: M12 and the 6809 E/Q clocks, a pixel enable,
//  and H/V counters with programmable totals and active windows.
//  Adds flip-screen counter outputs, three maskable interrupt sources and an N-frame delayed CPU reset.
//  It sits between the master clock and the tile fetch, scroll and CPU interface logic.
// PARAMETERS
//  H_TOTAL      384  pixels per line, including blank (even, >=16)
//  H_ACTIVE     320  visible pixels per line (<H_TOTAL)
//  V_TOTAL      264  lines per frame
//  V_ACTIVE     224  visible lines per frame; IRQ line = V_ACTIVE
//  FIRQ_FRAMES  2    FIRQ trigger period in frames (>=1)
//  NMI_LINES    32   NMI trigger period in lines (>=1)
//  RST_FRAMES   8    frames RST is held low after reset (1..255)
//  HW / VW      $clog2(H_TOTAL) / $clog2(V_TOTAL)  derived widths, not overridable
// PORTS
//  M24     in   1   master clock; every flop is on its rising edge
//  RES     in   1   asynchronous reset, active-high
//  FLIP    in   1   flip screen; XORs the flipped counter outputs
//  INT_EN  in   3   [2]=IRQ [1]=FIRQ [0]=NMI enables; 0 = masked and acknowledged
//  M12     out  1   M24/2
//  PE, PQ  out  1   6809 E and Q clocks, M24/4, Q leads E by 90 degrees
//  PIX_CE  out  1   one-M24-cycle pixel enable, 6 MHz
//  HCNT    out  HW  raw horizontal position
//  VCNT    out  VW  raw vertical position
//  HCNT_F  out  HW  HCNT[HW-1:3] XOR {FLIP}, HCNT[2:0] passed through
//  HBLK    out  1   1 when HCNT >= H_ACTIVE
//  VBLK    out  1   1 when VCNT >= V_ACTIVE
//  LINE_END out 1   1 for the PIX_CE cycle where HCNT==H_TOTAL-1
//  IRQ_N, FIRQ_N, NMI_N  out 1  active-low interrupt lines
//  RST     out  1   delayed CPU reset, active-low
// BEHAVIOUR
//  - Reset, asynchronous on RES=1:
//    ph=0, HCNT=0, VCNT=0, frame counter and line counter =0.
//    IRQ_N=FIRQ_N=NMI_N=1, RST=0, M12=PE=PQ=PIX_CE=0.
//  - Phase counter ph[1:0] increments every M24. Outputs are registered so they track ph with no skew:
//    M12=ph[0].
//    ph 0/1/2/3 -> (PE,PQ) = 00/01/11/10.
//    PIX_CE=1 only when ph==3.
//  - On PIX_CE: HCNT increments; at H_TOTAL-1 it wraps to 0 and VCNT increments.
//    VCNT wraps to 0 at V_TOTAL-1. Both counters hold between PIX_CE pulses.
//  - HBLK, VBLK and HCNT_F are combinational from the registered counters and FLIP.
//    A FLIP change takes effect in the same cycle.
//  - Triggers are single M24 cycles, qualified by PIX_CE and the counter wrap:
//    - T_IRQ: the wrap that makes VCNT==V_ACTIVE.
//    - T_NMI: line wrap where (line counter mod NMI_LINES)==NMI_LINES-1.
//      The line counter is free-running and is not reset at frame start.
//    - T_FIRQ: every FIRQ_FRAMES-th T_IRQ (frame counter wraps).
//  - Interrupt flag x (IRQ, FIRQ or NMI), evaluated per M24 cycle:
//    - INT_EN[x]=0 forces x_N=1, and this has priority over a trigger in the same cycle.
//    - Otherwise, trigger -> x_N=0, registered, so the line falls in the next cycle.
//    - Otherwise x_N holds.
//    - A second trigger while x_N is already 0 has no effect; there is no queueing.
//  - RST delay: a counter counts T_IRQ pulses after reset. RST goes 1 on the RST_FRAMES-th T_IRQ and stays 1.
//    Further T_IRQ pulses do not change it. The counter saturates and does not wrap.
//  - RES asserted mid-frame returns every state immediately to its reset value. The RST delay restarts in full.
//  - No combinational path from INT_EN to any output. All outputs except HBLK, VBLK and HCNT_F are flop outputs.
// TESTING
//  1 Release RES, run 16 M24 cycles -> (PE,PQ) sequence 00,01,11,10 repeats; M12 toggles every cycle;
//    PIX_CE pulses at cycles 3,7,11,15.
//  2 Defaults, run one frame (384*264*4 M24) -> LINE_END at HCNT=383; VCNT wraps 263->0;
//    HBLK rises at HCNT=320; VBLK rises at VCNT=224.
//  3 INT_EN=3'b100 -> IRQ_N falls the cycle after VCNT becomes 224; FIRQ_N and NMI_N stay 1.
//    INT_EN[2]=0 on the trigger cycle -> IRQ_N stays 1.
//  4 INT_EN=3'b001, NMI_LINES=32 -> NMI_N falls every 32 lines. A pulse of INT_EN[0]=0 clears it.
//    A retrigger with the flag still low is not queued.
//  5 RST_FRAMES=8 -> RST stays 0 through 7 VCNT==224 events and rises on the 8th.
//    RES mid-frame 3 -> RST=0 and 8 full frames are needed again.
//  6 FLIP=1 with HCNT=0x05A -> HCNT_F=0x1A2; toggling FLIP changes HCNT_F in the same cycle and HCNT stays unchanged.

Source files
------------

// File: rtl/tile_timing_gen.sv
// tile_timing_gen: clock phases, H/V raster counters, maskable interrupts and frame-delayed CPU reset.
module tile_timing_gen #(
  parameter int H_TOTAL     = 384,
  parameter int H_ACTIVE    = 320,
  parameter int V_TOTAL     = 264,
  parameter int V_ACTIVE    = 224,
  parameter int FIRQ_FRAMES = 2,
  parameter int NMI_LINES   = 32,
  parameter int RST_FRAMES  = 8,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          M24,
  input  logic          RES,
  input  logic          FLIP,
  input  logic [2:0]    INT_EN,
  output logic          M12,
  output logic          PE,
  output logic          PQ,
  output logic          PIX_CE,
  output logic [HW-1:0] HCNT,
  output logic [VW-1:0] VCNT,
  output logic [HW-1:0] HCNT_F,
  output logic          HBLK,
  output logic          VBLK,
  output logic          LINE_END,
  output logic          IRQ_N,
  output logic          FIRQ_N,
  output logic          NMI_N,
  output logic          RST
);
  localparam int LW = $clog2(NMI_LINES + 1);
  localparam int FW = $clog2(FIRQ_FRAMES + 1);
  logic [1:0]    ph_q, ph_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic m12_q, pe_q, pq_q, pix_ce_q, line_end_q, irq_n_q, firq_n_q, nmi_n_q, rst_q;
  logic irq_n_d, firq_n_d, nmi_n_d;
  logic pce, h_wrap, t_irq, t_nmi, t_firq;
  always_comb begin
    pce      = ph_q == 2'd3;
    h_wrap   = pce && hcnt_q == HW'(H_TOTAL - 1);
    t_irq    = h_wrap && vcnt_q == VW'(V_ACTIVE - 1);
    t_nmi    = h_wrap && lcnt_q == LW'(NMI_LINES - 1);
    t_firq   = t_irq && fcnt_q == FW'(FIRQ_FRAMES - 1);
    ph_d     = ph_q + 2'd1;
    hcnt_d   = h_wrap ? '0 : hcnt_q + HW'(pce);
    vcnt_d   = !h_wrap ? vcnt_q : vcnt_q == VW'(V_TOTAL - 1) ? '0 : vcnt_q + VW'(1);
    lcnt_d   = !h_wrap ? lcnt_q : t_nmi ? '0 : lcnt_q + LW'(1);
    fcnt_d   = !t_irq ? fcnt_q : t_firq ? '0 : fcnt_q + FW'(1);
    rcnt_d   = (t_irq && rcnt_q != 8'(RST_FRAMES)) ? rcnt_q + 8'd1 : rcnt_q;
    // a cleared enable wins over a trigger landing in the same cycle
    irq_n_d  = !INT_EN[2] || (!t_irq && irq_n_q);
    firq_n_d = !INT_EN[1] || (!t_firq && firq_n_q);
    nmi_n_d  = !INT_EN[0] || (!t_nmi && nmi_n_q);
  end
  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      ph_q       <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      lcnt_q     <= '0;
      fcnt_q     <= '0;
      rcnt_q     <= '0;
      m12_q      <= 1'b0;
      pe_q       <= 1'b0;
      pq_q       <= 1'b0;
      pix_ce_q   <= 1'b0;
      line_end_q <= 1'b0;
      irq_n_q    <= 1'b1;
      firq_n_q   <= 1'b1;
      nmi_n_q    <= 1'b1;
      rst_q      <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      lcnt_q     <= lcnt_d;
      fcnt_q     <= fcnt_d;
      rcnt_q     <= rcnt_d;
      // phase outputs are decoded from the next phase so they line up with ph_q
      m12_q      <= ph_d[0];
      pe_q       <= ph_d[1];
      pq_q       <= ph_d[1] ^ ph_d[0];
      pix_ce_q   <= ph_d == 2'd3;
      line_end_q <= ph_d == 2'd3 && hcnt_d == HW'(H_TOTAL - 1);
      irq_n_q    <= irq_n_d;
      firq_n_q   <= firq_n_d;
      nmi_n_q    <= nmi_n_d;
      rst_q      <= rcnt_d == 8'(RST_FRAMES);
    end
  end
  assign M12      = m12_q;
  assign PE       = pe_q;
  assign PQ       = pq_q;
  assign PIX_CE   = pix_ce_q;
  assign LINE_END = line_end_q;
  assign IRQ_N    = irq_n_q;
  assign FIRQ_N   = firq_n_q;
  assign NMI_N    = nmi_n_q;
  assign RST      = rst_q;
  assign HCNT     = hcnt_q;
  assign VCNT     = vcnt_q;
  assign HCNT_F   = {hcnt_q[HW-1:3] ^ {(HW-3){FLIP}}, hcnt_q[2:0]};
  assign HBLK     = hcnt_q >= HW'(H_ACTIVE);
  assign VBLK     = vcnt_q >= VW'(V_ACTIVE);
endmodule

// File: tb/tb_tile_timing_gen.sv
// tb_tile_timing_gen: directed bench with an arithmetic per-cycle reference and a scoreboard queue.
module tb_tile_timing_gen;
  localparam int HT = 128, HA = 100, VT = 10, VA = 6, FF = 2, NL = 4, RF = 4;
  localparam int HW = 7, VW = 4;
  localparam int T1 = VA * HT * 4;
  localparam int FR = HT * VT * 4;
  logic M24 = 1'b0, RES = 1'b1, FLIP = 1'b0;
  logic [2:0] INT_EN = 3'b000;
  logic M12, PE, PQ, PIX_CE, HBLK, VBLK, LINE_END, IRQ_N, FIRQ_N, NMI_N, RST;
  logic [HW-1:0] HCNT, HCNT_F;
  logic [VW-1:0] VCNT;
  int checks = 0, failures = 0, n = 0;
  logic [28:0] sb_q[$];
  tile_timing_gen #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
    .FIRQ_FRAMES(FF), .NMI_LINES(NL), .RST_FRAMES(RF)) dut (
    .M24(M24), .RES(RES), .FLIP(FLIP), .INT_EN(INT_EN), .M12(M12), .PE(PE), .PQ(PQ),
    .PIX_CE(PIX_CE), .HCNT(HCNT), .VCNT(VCNT), .HCNT_F(HCNT_F), .HBLK(HBLK), .VBLK(VBLK),
    .LINE_END(LINE_END), .IRQ_N(IRQ_N), .FIRQ_N(FIRQ_N), .NMI_N(NMI_N), .RST(RST));
  always #5 M24 = ~M24;
  function automatic logic [28:0] exp_vec(input int c);
    int ph, p, h, v, irqs;
    logic [6:0] hv;
    logic [3:0] vv;
    ph   = c % 4;
    p    = c / 4;
    h    = p % HT;
    v    = (p / HT) % VT;
    irqs = (c >= T1) ? (c - T1) / FR + 1 : 0;
    hv   = 7'(h);
    vv   = 4'(v);
    return {ph == 1 || ph == 3, ph == 2 || ph == 3, ph == 1 || ph == 2, ph == 3,
            ph == 3 && h == HT - 1, h >= HA, v >= VA, 3'b111, irqs >= RF, hv, vv, hv};
  endfunction
  function automatic logic [28:0] obs_vec();
    return {M12, PE, PQ, PIX_CE, LINE_END, HBLK, VBLK, IRQ_N, FIRQ_N, NMI_N, RST, HCNT, VCNT, HCNT_F};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge M24);
    #1;
    n++;
  endtask
  task automatic release_reset();
    RES = 1'b1;
    #1;
    chk("reset_state", 32'(obs_vec()), 32'(exp_vec(0)));
    tick();
    RES = 1'b0;
    n = 0;
  endtask
  task automatic run_check(input int target);
    while (n < target) begin
      sb_q.push_back(exp_vec(n + 1));
      tick();
      chk("cycle", 32'(obs_vec()), 32'(sb_q.pop_front()));
    end
  endtask
  task automatic run_to(input int target);
    while (n < target) tick();
  endtask
  initial begin
    repeat (3) @(posedge M24);
    #1;
    release_reset();
    run_check(360);
    FLIP = 1'b1;
    #1;
    chk("flip_hcnt_f", 32'(HCNT_F), 32'h22);
    chk("flip_hcnt", 32'(HCNT), 32'h5A);
    FLIP = 1'b0;
    #1;
    chk("unflip_hcnt_f", 32'(HCNT_F), 32'h5A);
    run_check(FR * 2 + FR / 2);
    RES = 1'b1;
    #1;
    chk("midframe_rst", 32'(RST), 32'(0));
    chk("midframe_hcnt", 32'(HCNT), 32'(0));
    release_reset();
    run_check(T1 + (RF - 1) * FR + 8);
    release_reset();
    INT_EN = 3'b100;
    run_to(T1 - 1);
    chk("irq_before", 32'(IRQ_N), 32'(1));
    tick();
    chk("irq_fall", 32'(IRQ_N), 32'(0));
    chk("irq_vcnt", 32'(VCNT), 32'(VA));
    chk("irq_firq_idle", 32'(FIRQ_N), 32'(1));
    chk("irq_nmi_idle", 32'(NMI_N), 32'(1));
    run_to(4000);
    INT_EN = 3'b000;
    tick();
    chk("irq_clear", 32'(IRQ_N), 32'(1));
    INT_EN = 3'b110;
    run_to(T1 + FR - 1);
    chk("firq_before", 32'(FIRQ_N), 32'(1));
    INT_EN = 3'b010;
    tick();
    chk("irq_masked_trigger", 32'(IRQ_N), 32'(1));
    chk("firq_fall", 32'(FIRQ_N), 32'(0));
    INT_EN = 3'b111;
    tick();
    chk("irq_no_queue", 32'(IRQ_N), 32'(1));
    run_to(512 * 19 + 511);
    chk("nmi_before", 32'(NMI_N), 32'(1));
    tick();
    chk("nmi_fall", 32'(NMI_N), 32'(0));
    run_to(10300);
    INT_EN = 3'b110;
    tick();
    chk("nmi_clear", 32'(NMI_N), 32'(1));
    INT_EN = 3'b111;
    run_to(512 * 23 + 512);
    chk("nmi_refall", 32'(NMI_N), 32'(0));
    run_to(T1 + 2 * FR - 1);
    chk("irq3_before", 32'(IRQ_N), 32'(1));
    tick();
    chk("irq3_fall", 32'(IRQ_N), 32'(0));
    run_to(14400);
    chk("nmi_held", 32'(NMI_N), 32'(0));
    INT_EN = 3'b110;
    tick();
    chk("nmi_clear2", 32'(NMI_N), 32'(1));
    INT_EN = 3'b111;
    run_to(14500);
    chk("nmi_not_queued", 32'(NMI_N), 32'(1));
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
